cntr8_ctrl: RTL
===============

Name: cntr8_ctrl

Overview:
- 8-state (3-bit) up/down counter stage.
- Next-state logic feeds a 3-bit async-reset state register and produces the count consumed by the shifter/display stages.
- Adds synchronous load, direction tracking and a one-cycle wrap pulse.
- Single clock domain; all outputs registered.

Parameters:
- RST_VAL, 3'b000, count value loaded on reset; range 0..7.
- WRAP_PULSE, 1, 1 = wrap output pulses on wrap-around; 0 = wrap tied to 0.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- load  input  1  synchronous load of d_in, highest priority
- d_in  input  3  load value
- inc  input  1  count up request
- dec  input  1  count down request
- q  output  3  current count (register output)
- dir  output  1  last applied direction: 1 = up, 0 = down
- wrap  output  1  one-cycle pulse: previous edge wrapped 7->0 or 0->7
- busy  output  1  1 while state is UP or DOWN (counted on last edge)

Behaviour:
- Reset (reset_n = 0, asynchronous, independent of clk):
  - q = RST_VAL, dir = 1, wrap = 0, busy = 0, FSM = IDLE.
  - Reset asserted mid-count overrides immediately; no partial update survives.
- Release: first rising edge with reset_n = 1 evaluates inputs normally. No extra synchronisation stage is inside this block.
- Per rising edge, priority:
  - load = 1: q <= d_in; dir unchanged; wrap <= 0; FSM -> IDLE.
  - else inc = 1 and dec = 1: hold q; wrap <= 0; FSM -> IDLE.
  - else inc = 1: q <= q + 1 modulo 8; dir <= 1; FSM -> UP.
  - else dec = 1: q <= q - 1 modulo 8; dir <= 0; FSM -> DOWN.
  - else: hold; wrap <= 0; FSM -> IDLE.
- Wrap: wrap <= 1 exactly when the applied step takes 7->0 (inc) or 0->7 (dec); otherwise 0. Forced 0 when WRAP_PULSE = 0.
- FSM states: IDLE, UP, DOWN (2-bit encoding). Transitions depend only on the applied action above; any state -> any state in one edge. busy = (state != IDLE).
- Latency: one clock from input to q/dir/wrap/busy. Inputs are sampled only at the rising edge; glitches between edges are ignored.
- Arithmetic: 3-bit unsigned, carry/borrow discarded except for wrap detection.
- Load of d_in equal to current q still forces FSM -> IDLE and wrap = 0.

Optional Feature:
- Macro CNTR8_SAT_EN.
- Defined:
  - Counter saturates: inc at 7 holds 7; dec at 0 holds 0.
  - wrap never asserts.
  - FSM goes to IDLE on a saturated (blocked) step; dir still updates to the requested direction.
- Undefined: modulo-8 wrap behaviour as above.

Decomposition:
- Shared package cntr8_pkg:
  - state typedef/localparams: ST_IDLE = 2'b00, ST_UP = 2'b01, ST_DOWN = 2'b10.
  - CNTR_W = 3, CNTR_MAX = 3'd7.
- One natural sub-module: cntr8_ns, combinational next-state/next-output logic (next_q, next_dir, next_wrap, next_state).
- Top instantiates cntr8_ns plus the 3-bit async-reset state register and flag flops.

Test Plan:
- Reset: hold reset_n = 0 with clk toggling and inc = 1 -> q = 000, dir = 1, wrap = 0, busy = 0. Assert reset_n = 0 mid-count at q = 5, between edges -> q = 000 immediately.
- Up wrap: from 000, inc = 1 for 8 edges -> q = 001..111, 000; wrap = 1 only in the cycle after the 111->000 edge; busy = 1 throughout.
- Down wrap: from 000, dec = 1 one edge -> q = 111, wrap = 1, dir = 0. Then idle one edge -> wrap = 0, busy = 0, q = 111.
- Load priority: q = 3, load = 1, d_in = 110, inc = 1 -> q = 110, wrap = 0, busy = 0, dir unchanged.
- Simultaneous inc & dec: q = 4 -> q stays 4, busy = 0, dir unchanged. Then inc only -> q = 5.
- CNTR8_SAT_EN build: q = 7 with inc -> q stays 7, wrap = 0, busy = 0. q = 0 with dec -> q stays 0, dir = 0.

Source files
------------

// File: rtl/cntr8_pkg.sv
// Shared types and constants for the cntr8 up/down counter stage.
package cntr8_pkg;

  localparam int unsigned CNTR_W = 3;
  localparam logic [CNTR_W-1:0] CNTR_MAX = 3'd7;

  // Controller state: IDLE when the last edge did not step the counter.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_UP   = 2'b01,
    ST_DOWN = 2'b10
  } state_e;

endpackage

// File: rtl/cntr8_ctrl_if.sv
// Control/status bundle for cntr8_ctrl: load/step requests in, count and flags out.
interface cntr8_ctrl_if;
  import cntr8_pkg::*;

  logic              load;
  logic [CNTR_W-1:0] d_in;
  logic              inc;
  logic              dec;
  logic [CNTR_W-1:0] q;
  logic              dir;
  logic              wrap;
  logic              busy;

  modport master (
    output load, d_in, inc, dec,
    input  q, dir, wrap, busy
  );

  modport slave (
    input  load, d_in, inc, dec,
    output q, dir, wrap, busy
  );

endinterface

// File: rtl/cntr8_ns.sv
// Combinational next-state logic for the cntr8 counter stage.
// Optional saturation (no wrap-around) is selected with macro CNTR8_SAT_EN.
module cntr8_ns
  import cntr8_pkg::*;
#(
  parameter bit WRAP_PULSE = 1'b1
) (
  input  logic [CNTR_W-1:0] q,
  input  logic              dir,
  input  logic              load,
  input  logic [CNTR_W-1:0] d_in,
  input  logic              inc,
  input  logic              dec,
  output logic [CNTR_W-1:0] next_q,
  output logic              next_dir,
  output logic              next_wrap,
  output state_e            next_state
);

  // Priority: load, then inc&dec cancel, then inc, then dec, else hold.
  always_comb begin
    next_q     = q;
    next_dir   = dir;
    next_wrap  = 1'b0;
    next_state = ST_IDLE;
    if (load) begin
      next_q = d_in;
    end else if (inc && dec) begin
      next_q = q;
    end else if (inc) begin
      next_dir = 1'b1;
`ifdef CNTR8_SAT_EN
      // Blocked step at the top: hold and report idle.
      if (q != CNTR_MAX) begin
        next_q     = q + 3'd1;
        next_state = ST_UP;
      end
`else
      next_q     = q + 3'd1;
      next_wrap  = WRAP_PULSE && (q == CNTR_MAX);
      next_state = ST_UP;
`endif
    end else if (dec) begin
      next_dir = 1'b0;
`ifdef CNTR8_SAT_EN
      // Blocked step at the bottom: hold and report idle.
      if (q != '0) begin
        next_q     = q - 3'd1;
        next_state = ST_DOWN;
      end
`else
      next_q     = q - 3'd1;
      next_wrap  = WRAP_PULSE && (q == '0);
      next_state = ST_DOWN;
`endif
    end
  end

endmodule

// File: rtl/cntr8_ctrl.sv
// 3-bit up/down counter stage with synchronous load, direction tracking and
// a one-cycle wrap pulse. All outputs come straight from flops.
// Macro CNTR8_SAT_EN selects saturating instead of modulo-8 counting.
module cntr8_ctrl
  import cntr8_pkg::*;
#(
  parameter logic [CNTR_W-1:0] RST_VAL    = 3'b000,
  parameter bit                WRAP_PULSE = 1'b1
) (
  input logic         clk,
  input logic         reset_n,
  cntr8_ctrl_if.slave bus
);

  logic [CNTR_W-1:0] count_q, count_d;
  logic              dir_q, dir_d;
  logic              wrap_q, wrap_d;
  state_e            state_q, state_d;

  cntr8_ns #(
    .WRAP_PULSE (WRAP_PULSE)
  ) u_ns (
    .q          (count_q),
    .dir        (dir_q),
    .load       (bus.load),
    .d_in       (bus.d_in),
    .inc        (bus.inc),
    .dec        (bus.dec),
    .next_q     (count_d),
    .next_dir   (dir_d),
    .next_wrap  (wrap_d),
    .next_state (state_d)
  );

  // Count, direction, wrap flag and FSM state; reset wins asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= RST_VAL;
      dir_q   <= 1'b1;
      wrap_q  <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
      state_q <= state_d;
    end
  end

  // Outputs are direct flop values; busy decodes the registered state.
  always_comb begin
    bus.q    = count_q;
    bus.dir  = dir_q;
    bus.wrap = wrap_q;
    bus.busy = (state_q != ST_IDLE);
  end

endmodule
